// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: data width, reset PC, bubble encoding and opcode constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            pc_src_e;
    logic [XLEN-1:0] pc_target_e;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_plus4_d;
    logic            valid_d;
    logic [XLEN-1:0] fetch_count;

    modport master (
        input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
        output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count
    );

    modport slave (
        output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
        input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, else stall holds, else load from fetch.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic [XLEN-1:0] instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_plus4_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    logic [XLEN-1:0] instr_q, instr_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_n;
    logic            valid_q, valid_n;

    always_comb begin
        instr_n    = instr_q;
        pc_n       = pc_q;
        pc_plus4_n = pc_plus4_q;
        valid_n    = valid_q;
        if (flush) begin
            instr_n    = NOP_INSTR;
            pc_n       = '0;
            pc_plus4_n = '0;
            valid_n    = 1'b0;
        end else if (!stall) begin
            instr_n    = instr_f;
            pc_n       = pc_f;
            pc_plus4_n = pc_plus4_f;
            valid_n    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_n;
            pc_q       <= pc_n;
            pc_plus4_q <= pc_plus4_n;
            valid_q    <= valid_n;
        end
    end

    assign instr_d    = instr_q;
    assign pc_d       = pc_q;
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, IF/ID register, fetch counter.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] count_q, count_n;
    logic            id_load;

    assign pc_plus4_f = pc_q + 32'd4;

    // Redirect wins over stall_f so a taken branch is never lost behind a hazard.
    always_comb begin
        pc_n = pc_plus4_f;
        if (bus.pc_src_e) begin
            pc_n = align_word(bus.pc_target_e);
        end else if (bus.stall_f) begin
            pc_n = pc_q;
        end
    end

    // Depends only on control inputs, so an X instruction word cannot disturb the count.
    assign id_load = !bus.flush_d && !bus.stall_d;

    always_comb begin
        count_n = count_q;
        if (id_load) begin
            count_n = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_n;
            count_q <= count_n;
        end
    end

    logic [XLEN-1:0] instr_d, pc_d, pc_plus4_d;
    logic            valid_d;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.flush_d),
        .stall      (bus.stall_d),
        .instr_f    (bus.imem_rdata),
        .pc_f       (pc_q),
        .pc_plus4_f (pc_plus4_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.instr_d     = instr_d;
    assign bus.pc_d        = pc_d;
    assign bus.pc_plus4_d  = pc_plus4_d;
    assign bus.valid_d     = valid_d;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with an address-derived instruction memory.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam logic [31:0] KEY = 32'hCAFE_0000;

    logic clk;
    logic rst;
    logic xmode;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word = address ^ KEY, or X when requested.
    assign bus.imem_rdata = xmode ? 32'hxxxx_xxxx : (bus.imem_addr ^ KEY);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic sf, input logic sd, input logic fd, input logic ps,
                           input logic [31:0] tgt);
        bus.stall_f     = sf;
        bus.stall_d     = sd;
        bus.flush_d     = fd;
        bus.pc_src_e    = ps;
        bus.pc_target_e = tgt;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " imem_addr"}, bus.imem_addr, RESET_PC_DEFAULT);
        check_eq({tag, " instr_d"}, bus.instr_d, NOP_INSTR_DEFAULT);
        check_eq({tag, " pc_d"}, bus.pc_d, 32'h0);
        check_eq({tag, " pc_plus4_d"}, bus.pc_plus4_d, 32'h0);
        check_eq({tag, " valid_d"}, {31'h0, bus.valid_d}, 32'h0);
        check_eq({tag, " fetch_count"}, bus.fetch_count, 32'h0);
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                            input logic [31:0] next_pc);
        check_eq({tag, " instr_d"}, bus.instr_d, pc ^ KEY);
        check_eq({tag, " pc_d"}, bus.pc_d, pc);
        check_eq({tag, " pc_plus4_d"}, bus.pc_plus4_d, pc + 32'd4);
        check_eq({tag, " valid_d"}, {31'h0, bus.valid_d}, 32'h1);
        check_eq({tag, " fetch_count"}, bus.fetch_count, cnt);
        check_eq({tag, " imem_addr"}, bus.imem_addr, next_pc);
    endtask

    task automatic check_bubble(input string tag, input logic [31:0] cnt,
                                input logic [31:0] next_pc);
        check_eq({tag, " instr_d"}, bus.instr_d, 32'h0000_0013);
        check_eq({tag, " pc_d"}, bus.pc_d, 32'h0);
        check_eq({tag, " pc_plus4_d"}, bus.pc_plus4_d, 32'h0);
        check_eq({tag, " valid_d"}, {31'h0, bus.valid_d}, 32'h0);
        check_eq({tag, " fetch_count"}, bus.fetch_count, cnt);
        check_eq({tag, " imem_addr"}, bus.imem_addr, next_pc);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        xmode  = 1'b0;
        rst    = 1'b0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #12;
        check_reset_vals("reset");
        #10 rst = 1'b1;

        // Straight-line fetch.
        step();
        check_id("seq0", 32'h0, 32'd1, 32'h4);
        repeat (3) step();
        check_id("seq3", 32'hC, 32'd4, 32'h10);

        // Full stall for 3 cycles at 0x10.
        set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        check_id("stall", 32'hC, 32'd4, 32'h10);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_id("resume", 32'h10, 32'd5, 32'h14);
        repeat (3) step();
        check_id("pre_redir", 32'h1C, 32'd8, 32'h20);

        // Redirect with flush, misaligned target.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        step();
        check_bubble("redir", 32'd8, 32'h100);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_id("post_redir", 32'h100, 32'd9, 32'h104);

        // Redirect and flush override both stalls.
        set_ctl(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        step();
        check_bubble("redir_stall", 32'd9, 32'h200);

        // stall_f only: duplicate fetch of the same PC is counted.
        set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_id("dup1", 32'h200, 32'd10, 32'h200);
        step();
        check_id("dup2", 32'h200, 32'd11, 32'h200);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_id("dup_rel", 32'h200, 32'd12, 32'h204);

        // stall_d only: PC advances, IF/ID holds.
        set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_id("stall_d", 32'h200, 32'd12, 32'h208);

        // PC wrap at the top of the address space.
        set_ctl(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step();
        check_bubble("to_top", 32'd12, 32'hFFFF_FFFC);
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_eq("wrap instr_d", bus.instr_d, 32'h3501_FFFC);
        check_eq("wrap pc_d", bus.pc_d, 32'hFFFF_FFFC);
        check_eq("wrap pc_plus4_d", bus.pc_plus4_d, 32'h0);
        check_eq("wrap imem_addr", bus.imem_addr, 32'h0);
        check_eq("wrap fetch_count", bus.fetch_count, 32'd13);

        // Unknown instruction word must not disturb valid_d or fetch_count.
        xmode = 1'b1;
        step();
        xmode = 1'b0;
        check_eq("xdata valid_d", {31'h0, bus.valid_d}, 32'h1);
        check_eq("xdata fetch_count", bus.fetch_count, 32'd14);
        check_eq("xdata imem_addr", bus.imem_addr, 32'h4);

        // Asynchronous reset between edges.
        #3 rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step();
        check_id("after_rst", 32'h0, 32'd1, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
